// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader: frame marker, loader states and
// the instruction word width.
package program_loader_pkg;

  localparam int INSTR_W = 32;
  localparam logic [7:0] SYNC_BYTE_DFLT = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    COUNT,
    PAYLOAD,
    CHECK,
    RUN,
    ERROR
  } state_t;

endpackage

// File: rtl/loader_image_reg.sv
// Instruction image register bank: synchronous clear, single-byte writes
// addressed by word and lane, flat little-endian output.
module loader_image_reg
  import program_loader_pkg::*;
#(
  parameter int N_WORDS = 32,
  parameter int WIDX_W  = 5
) (
  input  logic                         clk,
  input  logic                         clr,
  input  logic                         wr_en,
  input  logic [WIDX_W-1:0]            wr_word,
  input  logic [1:0]                   wr_lane,
  input  logic [7:0]                   wr_byte,
  output logic [INSTR_W*N_WORDS-1:0]   image
);

  // {word, lane, 3'b0} is the bit offset of the addressed byte.
  always_ff @(posedge clk) begin
    if (clr) begin
      image <= '0;
    end else if (wr_en) begin
      image[{wr_word, wr_lane, 3'b000} +: 8] <= wr_byte;
    end
  end

endmodule

// File: rtl/program_loader.sv
// Framed byte-stream loader: assembles a checksummed instruction image and
// holds the core in reset until a complete, valid frame has been received.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int         N_WORDS   = 32,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DFLT
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    rx_data,
  input  logic                          rx_valid,
  output logic                          rx_ready,
  input  logic                          err_clear,
  output logic [INSTR_W*N_WORDS-1:0]    i_memory_out,
  output logic                          core_rstn,
  output logic                          load_busy,
  output logic                          load_err,
  output logic [$clog2(N_WORDS+1)-1:0]  words_loaded
);

  localparam int WL_W   = $clog2(N_WORDS + 1);
  localparam int WIDX_W = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;

  state_t          state_q, state_d;
  logic [WL_W-1:0] cnt_q, cnt_d;
  logic [WL_W-1:0] wl_d;
  logic [1:0]      lane_q, lane_d;
  logic [7:0]      chk_q, chk_d;
  logic            accept;
  logic            count_ok;
  logic            clear_img;
  logic            wr_en;

  assign accept   = rx_valid & rx_ready;
  assign count_ok = (rx_data != 8'd0) && ({24'd0, rx_data} <= 32'(N_WORDS));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      lane_q       <= '0;
      chk_q        <= '0;
      words_loaded <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      lane_q       <= lane_d;
      chk_q        <= chk_d;
      words_loaded <= wl_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    lane_d    = lane_q;
    chk_d     = chk_q;
    wl_d      = words_loaded;
    clear_img = 1'b0;
    wr_en     = 1'b0;
    case (state_q)
      IDLE, RUN: begin
        if (accept && rx_data == SYNC_BYTE) begin
          state_d   = COUNT;
          clear_img = 1'b1;
          wl_d      = '0;
          chk_d     = '0;
        end
      end
      COUNT: begin
        if (accept) begin
          if (count_ok) begin
            state_d = PAYLOAD;
            cnt_d   = WL_W'(rx_data);
            chk_d   = rx_data;
            lane_d  = '0;
          end else begin
            state_d = ERROR;
          end
        end
      end
      PAYLOAD: begin
        if (accept) begin
          wr_en  = 1'b1;
          chk_d  = chk_q ^ rx_data;
          lane_d = lane_q + 2'd1;
          if (lane_q == 2'd3) begin
            wl_d = words_loaded + WL_W'(1);
            if (words_loaded + WL_W'(1) == cnt_q) begin
              state_d = CHECK;
            end
          end
        end
      end
      CHECK: begin
        if (accept) begin
          state_d = (rx_data == chk_q) ? RUN : ERROR;
        end
      end
      ERROR: begin
        if (err_clear) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_ready  <= 1'b1;
      core_rstn <= 1'b0;
      load_busy <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      rx_ready  <= (state_d != ERROR);
      core_rstn <= (state_d == RUN);
      load_busy <= (state_d == COUNT) || (state_d == PAYLOAD) || (state_d == CHECK);
      load_err  <= (state_d == ERROR);
    end
  end

  loader_image_reg #(
    .N_WORDS (N_WORDS),
    .WIDX_W  (WIDX_W)
  ) u_image (
    .clk     (clk),
    .clr     (rst | clear_img),
    .wr_en   (wr_en),
    .wr_word (words_loaded[WIDX_W-1:0]),
    .wr_lane (lane_q),
    .wr_byte (rx_data),
    .image   (i_memory_out)
  );

endmodule

// File: tb/tb_program_loader.sv
// Randomized scoreboard bench for program_loader: frames are modelled as whole
// byte lists, and completion events on core_rstn/load_err are checked.
module tb_program_loader;
  import program_loader_pkg::*;

  localparam int N    = 32;
  localparam int IW   = 32 * N;
  localparam int WL_W = $clog2(N + 1);

  logic            clk;
  logic            rst;
  logic [7:0]      rx_data;
  logic            rx_valid;
  logic            rx_ready;
  logic            err_clear;
  logic [IW-1:0]   i_memory_out;
  logic            core_rstn;
  logic            load_busy;
  logic            load_err;
  logic [WL_W-1:0] words_loaded;

  program_loader #(.N_WORDS(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .err_clear    (err_clear),
    .i_memory_out (i_memory_out),
    .core_rstn    (core_rstn),
    .load_busy    (load_busy),
    .load_err     (load_err),
    .words_loaded (words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          is_err;
    logic [IW-1:0] img;
    int            wl;
  } exp_t;

  int          n_chk  = 0;
  int          n_fail = 0;
  exp_t        sb[$];
  logic [7:0]  frm[$];
  bit          gaps   = 0;

  task automatic check(input string name, input logic [IW-1:0] act, input logic [IW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: interpret a complete frame byte list directly.
  function automatic exp_t model();
    exp_t       r;
    int         c;
    logic [7:0] x;
    r.img    = '0;
    r.wl     = 0;
    r.is_err = 1'b1;
    c        = int'(frm[1]);
    if (c == 0 || c > N) return r;
    x = frm[1];
    for (int w = 0; w < c; w++) begin
      for (int l = 0; l < 4; l++) begin
        r.img[(w * 4 + l) * 8 +: 8] = frm[2 + 4 * w + l];
        x = x ^ frm[2 + 4 * w + l];
      end
    end
    r.wl     = c;
    r.is_err = (frm[2 + 4 * c] != x);
    return r;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    int n;
    if (gaps) begin
      rx_valid = 1'b0;
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    rx_data  = b;
    rx_valid = 1'b1;
    n        = 0;
    while (!rx_ready && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!rx_ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL rx_ready_timeout: got 0 expected 1");
    end
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic garbage(input int n);
    logic [7:0] g[3];
    g[0] = 8'h00;
    g[1] = 8'hFF;
    g[2] = 8'h5A;
    for (int i = 0; i < n; i++) send_byte(g[$urandom_range(0, 2)]);
  endtask

  // Send frm, check completion latency, recover from an error if one is expected.
  task automatic run_frame(input bit chk_after_sync);
    exp_t e;
    e = model();
    sb.push_back(e);
    for (int i = 0; i < frm.size(); i++) begin
      send_byte(frm[i]);
      if (i == 0 && chk_after_sync) begin
        check("reload_rstn", IW'(core_rstn), IW'(0));
        check("reload_image", i_memory_out, '0);
        check("reload_busy", IW'(load_busy), IW'(1));
      end
    end
    check("done_err", IW'(load_err), IW'(e.is_err));
    check("done_rstn", IW'(core_rstn), IW'(!e.is_err));
    if (e.is_err) begin
      check("err_ready", IW'(rx_ready), IW'(0));
      check("err_busy", IW'(load_busy), IW'(0));
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      err_clear = 1'b1;
      @(posedge clk);
      #1;
      err_clear = 1'b0;
      check("clr_ready", IW'(rx_ready), IW'(1));
      check("clr_err", IW'(load_err), IW'(0));
    end
  endtask

  task automatic make_frame(input int c, input bit corrupt);
    logic [7:0] x;
    frm.delete();
    frm.push_back(8'hA5);
    frm.push_back(8'(c));
    if (c == 0 || c > N) return;
    x = 8'(c);
    for (int i = 0; i < 4 * c; i++) begin
      frm.push_back(8'($urandom));
      x = x ^ frm[frm.size() - 1];
    end
    if (corrupt) x = x ^ 8'($urandom_range(1, 255));
    frm.push_back(x);
  endtask

  // Monitor: a rising core_rstn or load_err marks a finished frame.
  logic prev_rn  = 1'b0;
  logic prev_err = 1'b0;
  exp_t mon_e;
  always @(negedge clk) begin
    if (!rst && ((core_rstn && !prev_rn) || (load_err && !prev_err))) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_event: got rstn=%0b err=%0b expected none", core_rstn, load_err);
      end else begin
        mon_e = sb.pop_front();
        check("sb_err", IW'(load_err), IW'(mon_e.is_err));
        check("sb_rstn", IW'(core_rstn), IW'(!mon_e.is_err));
        check("sb_image", i_memory_out, mon_e.img);
        check("sb_words", IW'(words_loaded), IW'(mon_e.wl));
      end
    end
    prev_rn  = core_rstn;
    prev_err = load_err;
  end

  initial begin
    rst       = 1'b1;
    rx_valid  = 1'b0;
    rx_data   = 8'h00;
    err_clear = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_image", i_memory_out, '0);
    check("rst_rstn", IW'(core_rstn), IW'(0));
    check("rst_ready", IW'(rx_ready), IW'(1));
    check("rst_err", IW'(load_err), IW'(0));
    check("rst_words", IW'(words_loaded), IW'(0));
    check("rst_busy", IW'(load_busy), IW'(0));
    rst = 1'b0;

    frm = '{8'hA5, 8'h02, 8'h93, 8'h00, 8'h10, 8'h00, 8'h13, 8'h01, 8'h10, 8'h00, 8'h83};
    run_frame(0);
    check("good_lo", IW'(i_memory_out[63:0]), IW'(64'h00100113_00100093));

    frm = '{8'hA5, 8'h02, 8'h93, 8'h00, 8'h10, 8'h00, 8'h13, 8'h01, 8'h10, 8'h00, 8'h84};
    run_frame(0);

    frm = '{8'hA5, 8'h00};
    run_frame(0);
    frm = '{8'hA5, 8'h21};
    run_frame(0);

    gaps = 1;
    garbage(5);
    frm = '{8'hA5, 8'h02, 8'h93, 8'h00, 8'h10, 8'h00, 8'h13, 8'h01, 8'h10, 8'h00, 8'h83};
    run_frame(0);
    gaps = 0;

    frm = '{8'hA5, 8'h01, 8'h13, 8'h00, 8'h00, 8'h00, 8'h12};
    run_frame(1);
    check("reload_word0", IW'(i_memory_out[31:0]), IW'(32'h00000013));

    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h93);
    send_byte(8'h00);
    send_byte(8'h10);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("mid_image", i_memory_out, '0);
    check("mid_rstn", IW'(core_rstn), IW'(0));
    check("mid_ready", IW'(rx_ready), IW'(1));
    check("mid_busy", IW'(load_busy), IW'(0));

    for (int k = 0; k < 20; k++) begin
      int c;
      gaps = bit'($urandom_range(0, 1));
      garbage($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) c = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(N + 1, 255);
      else c = $urandom_range(1, N);
      make_frame(c, $urandom_range(0, 4) == 0);
      run_frame(0);
    end

    repeat (4) @(posedge clk);
    #1;
    check("sb_empty", IW'(sb.size()), IW'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
